// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package program_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects a big-endian byte stream into 32-bit words; word_valid pulses
// for one cycle in the cycle after the fourth byte of a word is accepted.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  count_q, count_d;
    logic [31:0] shift_q, shift_d;
    logic        valid_q, valid_d;

    // Shift in each accepted byte; flag the word when the counter wraps.
    always_comb begin
        count_d = count_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        if (clear) begin
            count_d = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            shift_d = {shift_q[23:0], byte_data};
            count_d = count_q + 2'd1;
            valid_d = (count_q == 2'(BYTES_PER_WORD - 1));
        end
    end

    // Byte counter, shift register and word strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid = valid_q;
    assign word       = shift_q;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, checksummed program into instruction memory and
// releases the CPU from reset once the checksum verifies.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_enable,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    output logic        cpu_hold,
    output logic        cpu_start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] words_loaded
);

    state_t      state_q, state_d;
    logic        load_en_q;
    logic [31:0] len_q, len_d;
    logic [31:0] checksum_q, checksum_d;
    logic [31:0] words_loaded_q, words_loaded_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic        mem_write_q, mem_write_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        cpu_start_q, cpu_start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        active, start, abort, word_valid;
    logic [31:0] word;

    assign active   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK);
    assign start    = load_enable & ~load_en_q & ~active;
    assign abort    = active & ~load_enable;
    assign in_ready = active;

    word_assembler u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (start),
        .byte_valid (in_valid & in_ready),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Next-state, memory write and CPU control decisions.
    always_comb begin
        state_d          = state_q;
        len_d            = len_q;
        checksum_d       = checksum_q;
        words_loaded_d   = words_loaded_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        mem_write_d      = 1'b0;
        cpu_hold_d       = cpu_hold_q;
        cpu_start_d      = 1'b0;
        busy_d           = busy_q;
        done_d           = done_q;
        error_d          = error_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d        = S_LEN;
                    done_d         = 1'b0;
                    error_d        = 1'b0;
                    words_loaded_d = '0;
                    checksum_d     = '0;
                    busy_d         = 1'b1;
                    cpu_hold_d     = 1'b1;
                end
            end
            S_LEN: begin
                if (word_valid) begin
                    len_d = word;
                    if (word == '0) begin
                        state_d = S_CHECK;
                    end else if (word > 32'(MAX_WORDS)) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_valid) begin
                    mem_write_d      = 1'b1;
                    mem_address_d    = 32'(BASE_ADDR) + words_loaded_q;
                    mem_write_data_d = word;
                    checksum_d       = checksum_q ^ word;
                    words_loaded_d   = words_loaded_q + 32'd1;
                    if (words_loaded_q + 32'd1 == len_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (word_valid) begin
                    busy_d = 1'b0;
                    if (word == checksum_q) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        cpu_hold_d  = 1'b0;
                        cpu_start_d = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides the state decision but not a write already decided above.
        if (abort) begin
            state_d     = S_ERROR;
            error_d     = 1'b1;
            done_d      = 1'b0;
            busy_d      = 1'b0;
            cpu_hold_d  = 1'b1;
            cpu_start_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= S_IDLE;
            load_en_q        <= 1'b0;
            len_q            <= '0;
            checksum_q       <= '0;
            words_loaded_q   <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_write_q      <= 1'b0;
            cpu_hold_q       <= 1'b1;
            cpu_start_q      <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            load_en_q        <= load_enable;
            len_q            <= len_d;
            checksum_q       <= checksum_d;
            words_loaded_q   <= words_loaded_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_write_q      <= mem_write_d;
            cpu_hold_q       <= cpu_hold_d;
            cpu_start_q      <= cpu_start_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            error_q          <= error_d;
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_write      = mem_write_q;
    assign mem_write_data = mem_write_data_q;
    assign cpu_hold       = cpu_hold_q;
    assign cpu_start      = cpu_start_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_loaded   = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a write-expectation queue built from
// the program contents is checked against every memory strobe.
module tb_program_loader;

    localparam int unsigned BASE = 0;

    logic        clock = 1'b0;
    logic        reset, load_enable, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_write, cpu_hold, cpu_start, busy, done, error;
    logic [31:0] mem_address, mem_write_data, words_loaded;

    int checks = 0;
    int errors = 0;
    int write_count = 0;
    int start_pulses = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] prog[$];

    program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
        .clock          (clock),
        .reset          (reset),
        .load_enable    (load_enable),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .cpu_hold       (cpu_hold),
        .cpu_start      (cpu_start),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .words_loaded   (words_loaded)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: program word i lands at BASE+i with its own value.
    task automatic expect_writes(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(32'(BASE) + 32'(i));
            exp_data.push_back(prog[i]);
        end
    endtask

    function automatic logic [31:0] xor_of(input int n);
        logic [31:0] x = '0;
        for (int i = 0; i < n; i++) x ^= prog[i];
        return x;
    endfunction

    // Every strobe must match the next expected write.
    always @(negedge clock) begin
        if (!reset) begin
            if (cpu_start) start_pulses++;
            if (mem_write) begin
                write_count++;
                if (exp_addr.size() == 0) begin
                    check("unexpected_write", mem_write, 1'b0);
                end else begin
                    check("write_addr", mem_address, exp_addr.pop_front());
                    check("write_data", mem_write_data, exp_data.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clock);
        while (!in_ready && t < 50) begin @(negedge clock); t++; end
        if (!in_ready) check("ready_timeout", in_ready, 1'b1);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gaps);
    endtask

    task automatic start_load();
        load_enable = 1'b0;
        @(posedge clock); #1;
        load_enable = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(done | error) && t < 100) begin @(posedge clock); #1; t++; end
        check("end_reached", done | error, 1'b1);
    endtask

    int w0, s0;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; load_enable = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_data", mem_write_data, 32'h0);
        check("rst_cpu_hold", cpu_hold, 1'b1);
        check("rst_cpu_start", cpu_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_words", words_loaded, 32'h0);

        // Good two-word program, exact completion latency.
        prog = '{32'h20010005, 32'h00221020};
        check("model_xor", xor_of(2), 32'h20231025);
        expect_writes(2);
        w0 = write_count; s0 = start_pulses;
        start_load();
        check("busy_in_load", busy, 1'b1);
        send_word(32'd2, 0);
        send_word(prog[0], 0);
        send_word(prog[1], 0);
        send_word(32'h20231025, 0);
        check("lat_done_not_yet", done, 1'b0);
        @(posedge clock); #1;
        check("lat_done", done, 1'b1);
        check("lat_cpu_start", cpu_start, 1'b1);
        check("lat_cpu_hold", cpu_hold, 1'b0);
        @(posedge clock); #1;
        check("start_one_cycle", cpu_start, 1'b0);
        check("t1_words", words_loaded, 32'd2);
        check("t1_writes", 32'(write_count - w0), 32'd2);
        check("t1_pulses", 32'(start_pulses - s0), 32'd1);
        check("t1_pending", 32'(exp_addr.size()), 32'd0);

        // Same program, wrong checksum.
        expect_writes(2);
        w0 = write_count; s0 = start_pulses;
        start_load();
        send_word(32'd2, 0);
        send_word(prog[0], 0);
        send_word(prog[1], 0);
        send_word(32'h00000000, 0);
        wait_end();
        repeat (2) @(posedge clock); #1;
        check("t2_error", error, 1'b1);
        check("t2_done", done, 1'b0);
        check("t2_hold", cpu_hold, 1'b1);
        check("t2_writes", 32'(write_count - w0), 32'd2);
        check("t2_pulses", 32'(start_pulses - s0), 32'd0);

        // Oversized length header.
        w0 = write_count;
        start_load();
        send_word(32'h00000101, 0);
        wait_end();
        check("t3_error", error, 1'b1);
        check("t3_busy", busy, 1'b0);
        check("t3_writes", 32'(write_count - w0), 32'd0);

        // Reset in the middle of a load.
        start_load();
        send_word(32'd2, 0);
        send_byte(8'h20, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", in_ready, 1'b0);
        check("mid_rst_hold", cpu_hold, 1'b1);
        check("mid_rst_error", error, 1'b0);

        // Empty program.
        w0 = write_count; s0 = start_pulses;
        start_load();
        send_word(32'd0, 0);
        send_word(32'd0, 0);
        wait_end();
        repeat (2) @(posedge clock); #1;
        check("t4_done", done, 1'b1);
        check("t4_words", words_loaded, 32'd0);
        check("t4_writes", 32'(write_count - w0), 32'd0);
        check("t4_pulses", 32'(start_pulses - s0), 32'd1);

        // Three words with random valid gaps.
        prog = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
        expect_writes(3);
        w0 = write_count;
        start_load();
        send_word(32'd3, 1);
        for (int i = 0; i < 3; i++) send_word(prog[i], 1);
        send_word(xor_of(3), 1);
        wait_end();
        check("t5_done", done, 1'b1);
        check("t5_words", words_loaded, 32'd3);
        check("t5_writes", 32'(write_count - w0), 32'd3);
        check("t5_pending", 32'(exp_addr.size()), 32'd0);

        // Abort partway through word 1, then a fresh load.
        prog = '{32'hAABBCCDD};
        expect_writes(1);
        w0 = write_count;
        start_load();
        send_word(32'd3, 0);
        send_word(prog[0], 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        load_enable = 1'b0;
        @(posedge clock); #1;
        check("abort_error", error, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_words", words_loaded, 32'd1);
        check("abort_writes", 32'(write_count - w0), 32'd1);
        load_enable = 1'b1;
        @(posedge clock); #1;
        check("reload_error_clear", error, 1'b0);
        check("reload_busy", busy, 1'b1);
        prog = '{32'h20010005, 32'h00221020};
        expect_writes(2);
        send_word(32'd2, 0);
        send_word(prog[0], 0);
        send_word(prog[1], 0);
        send_word(32'h20231025, 0);
        wait_end();
        check("reload_done", done, 1'b1);
        check("reload_error", error, 1'b0);
        check("reload_pending", 32'(exp_addr.size()), 32'd0);

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
